// File: rtl/slt_serial_pkg.sv
// slt_serial_pkg: shared constants for the serial set-less-than unit.
//   - FSM state encoding (plain 2-bit constants)
//   - default operand width
//   - digit-count helper used to size the index counter
package slt_serial_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DIGIT = 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Number of digits scanned for a given operand/digit width.
   function automatic int ndigits(input int width, input int digit);
      return width / digit;
   endfunction

   localparam int DEF_NDIG = ndigits(DEF_WIDTH, DEF_DIGIT);

endpackage

// File: rtl/slt_serial_cmp_if.sv
// slt_serial_cmp_if: start/done handshake between the ALU control FSM
// (master) and the serial comparator (slave).
//   start, is_signed, a, b : request, sampled by the slave in IDLE
//   busy, done, result, eq : status / registered result
interface slt_serial_cmp_if
   import slt_serial_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             result;
   logic             eq;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, result, eq
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, result, eq
   );
endinterface

// File: rtl/slt_serial_cmp_digit_cmp.sv
// digit_cmp: unsigned compare of one DIGIT-wide slice.
//   da, db : digit slices of the (MSB-flipped) operands
//   lt     : da < db
//   ne     : da != db
module digit_cmp #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] da,
   input  logic [DIGIT-1:0] db,
   output logic             lt,
   output logic             ne
);
   assign lt = (da < db);
   assign ne = (da != db);
endmodule

// File: rtl/slt_serial_cmp.sv
// slt_serial_cmp: multi-cycle SLT/SLTU. Scans the operands MSB-first one
// DIGIT per clock and stops at the first differing digit.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of slt_serial_cmp_if
//                (start/is_signed/a/b in, busy/done/result/eq out)
// DIGIT must divide WIDTH (1, 2, 4 or 8).
module slt_serial_cmp
   import slt_serial_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst_n,
   slt_serial_cmp_if.slave  bus
);
   localparam int NDIG = ndigits(WIDTH, DIGIT);
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic [1:0]       state;
   logic [WIDTH-1:0] ra, rb;
   logic [IW-1:0]    idx;
   logic             result_q, eq_q;

   logic [DIGIT-1:0] da, db;
   logic             dlt, dne;

   // Flipping the MSB of both operands turns a signed compare into an
   // unsigned one, so the scan below is always unsigned.
   logic [WIDTH-1:0] sflip;
   assign sflip = {bus.is_signed, {(WIDTH-1){1'b0}}};

   // Digit mux: select slice idx of each latched operand.
   always_comb begin
      da = '0;
      db = '0;
      for (int k = 0; k < NDIG; k++) begin
         if (idx == IW'(k)) begin
            da = ra[k*DIGIT +: DIGIT];
            db = rb[k*DIGIT +: DIGIT];
         end
      end
   end

   digit_cmp #(.DIGIT(DIGIT)) u_dcmp (
      .da (da),
      .db (db),
      .lt (dlt),
      .ne (dne)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ra       <= '0;
         rb       <= '0;
         idx      <= '0;
         result_q <= 1'b0;
         eq_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  ra       <= bus.a ^ sflip;
                  rb       <= bus.b ^ sflip;
                  idx      <= IW'(NDIG - 1);
                  result_q <= 1'b0;
                  eq_q     <= 1'b0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (dne) begin
                  result_q <= dlt;
                  eq_q     <= 1'b0;
                  state    <= DONE;
               end else if (idx == '0) begin
                  result_q <= 1'b0;
                  eq_q     <= 1'b1;
                  state    <= DONE;
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Status decodes straight from the state register; no input reaches
   // an output combinationally.
   assign bus.busy   = (state != IDLE);
   assign bus.done   = (state == DONE);
   assign bus.result = result_q;
   assign bus.eq     = eq_q;

endmodule

// File: tb/tb_slt_serial_cmp.sv
// tb_slt_serial_cmp: scoreboard bench for slt_serial_cmp, one instance with
// DIGIT=1 and one with DIGIT=4, both WIDTH=32.
module tb_slt_serial_cmp;

   logic clk;
   logic rst_n;
   int   cyc;
   int   total;
   int   bad;

   typedef struct {
      logic res;
      logic eq;
      int   n;
      int   t0;
   } exp_t;

   exp_t q1[$];
   exp_t q4[$];
   exp_t e1, e4;

   slt_serial_cmp_if #(.WIDTH(32)) if1 ();
   slt_serial_cmp_if #(.WIDTH(32)) if4 ();

   slt_serial_cmp #(.WIDTH(32), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   slt_serial_cmp #(.WIDTH(32), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Reference: result from native compare, latency from the first
   // differing digit counted from the MSB.
   function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic s, input int dg, input int t0);
      exp_t        e;
      logic [31:0] x;
      logic [31:0] m;
      int          nd;
      bit          found;
      x     = a ^ b;
      m     = (32'd1 << dg) - 32'd1;
      nd    = 32 / dg;
      found = 0;
      e.n   = nd;
      for (int k = nd - 1; k >= 0; k--) begin
         if (!found && (((x >> (k*dg)) & m) != 0)) begin
            found = 1;
            e.n   = nd - k;
         end
      end
      e.res = s ? ($signed(a) < $signed(b)) : (a < b);
      e.eq  = (a == b);
      e.t0  = t0;
      return e;
   endfunction

   // Monitors: every done pulse pops one expectation.
   always @(negedge clk) begin
      if (if1.done) begin
         if (q1.size() == 0) chk("d1_spurious_done", 1, 0);
         else begin
            e1 = q1.pop_front();
            chk("d1_result",  int'(if1.result), int'(e1.res));
            chk("d1_eq",      int'(if1.eq),     int'(e1.eq));
            chk("d1_latency", cyc - e1.t0,      e1.n);
         end
      end
   end

   always @(negedge clk) begin
      if (if4.done) begin
         if (q4.size() == 0) chk("d4_spurious_done", 1, 0);
         else begin
            e4 = q4.pop_front();
            chk("d4_result",  int'(if4.result), int'(e4.res));
            chk("d4_eq",      int'(if4.eq),     int'(e4.eq));
            chk("d4_latency", cyc - e4.t0,      e4.n);
         end
      end
   end

   // One-cycle start pulse; operands are scrambled after acceptance.
   task automatic launch(input bit sel, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit push);
      @(negedge clk);
      if (!sel) begin
         if1.start = 1'b1; if1.a = a; if1.b = b; if1.is_signed = s;
         if (push) q1.push_back(mk(a, b, s, 1, cyc + 1));
      end else begin
         if4.start = 1'b1; if4.a = a; if4.b = b; if4.is_signed = s;
         if (push) q4.push_back(mk(a, b, s, 4, cyc + 1));
      end
      @(negedge clk);
      if (!sel) begin
         if1.start = 1'b0; if1.a = $urandom; if1.b = $urandom; if1.is_signed = ~s;
      end else begin
         if4.start = 1'b0; if4.a = $urandom; if4.b = $urandom; if4.is_signed = ~s;
      end
   endtask

   // Counts busy cycles from the first SCAN cycle until IDLE, bounded.
   task automatic wait_idle(input bit sel, output int nb);
      nb = 0;
      while ((sel ? if4.busy : if1.busy) && nb < 200) begin
         nb++;
         @(negedge clk);
      end
      if (nb >= 200) chk("timeout", 1, 0);
   endtask

   task automatic op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input string tag);
      int   nb;
      exp_t e;
      e = mk(a, b, s, sel ? 4 : 1, 0);
      launch(sel, a, b, s, 1'b1);
      wait_idle(sel, nb);
      chk(tag, nb, e.n + 1);
   endtask

   initial begin
      int nb;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      if1.start = 0; if1.a = 0; if1.b = 0; if1.is_signed = 0;
      if4.start = 0; if4.a = 0; if4.b = 0; if4.is_signed = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy",   int'(if1.busy),   0);
      chk("rst_done",   int'(if1.done),   0);
      chk("rst_result", int'(if1.result), 0);
      chk("rst_eq",     int'(if1.eq),     0);
      rst_n = 1'b1;

      // DIGIT=1 directed cases
      op(0, 32'h11111111, 32'h99999999, 1'b0, "busy_u_lt");
      op(0, 32'h11111111, 32'h99999999, 1'b1, "busy_s_gt");
      op(0, 32'h99999999, 32'h11111111, 1'b1, "busy_s_lt");
      op(0, 32'h99999999, 32'h11111111, 1'b0, "busy_u_gt");
      op(0, 32'h11111111, 32'h11111111, 1'b0, "busy_equal33");
      op(0, 32'h00000001, 32'h00000002, 1'b0, "busy_n31_lt");
      op(0, 32'h00000002, 32'h00000001, 1'b0, "busy_n31_gt");
      op(0, 32'h80000000, 32'h80000000, 1'b1, "busy_s_eq");
      for (int i = 0; i < 6; i++)
         op(0, $urandom, $urandom, 1'(i & 1), "busy_rand");

      // Output hold after done
      chk("hold_result", int'(if1.result), int'(q1.size() == 0 ? e1.res : 1'b0));
      repeat (3) @(negedge clk);
      chk("hold_result_later", int'(if1.result), int'(e1.res));
      chk("hold_eq_later",     int'(if1.eq),     int'(e1.eq));

      // start while scanning is ignored
      launch(0, 32'h55555555, 32'h55555555, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      if1.start = 1'b1; if1.a = 32'h0; if1.b = 32'hFFFFFFFF; if1.is_signed = 1'b0;
      @(negedge clk);
      if1.start = 1'b0;
      wait_idle(0, nb);
      chk("ignored_start_q", q1.size(), 0);

      // start during the done cycle is ignored
      launch(0, 32'h00000000, 32'h80000000, 1'b0, 1'b1);
      @(negedge clk);
      chk("done_cycle", int'(if1.done), 1);
      if1.start = 1'b1; if1.a = 32'h1; if1.b = 32'h1;
      @(negedge clk);
      if1.start = 1'b0;
      chk("restart_in_done_busy", int'(if1.busy), 0);
      chk("restart_in_done_res",  int'(if1.result), 1);

      // Reset mid-scan: no done, outputs cleared
      launch(0, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy",   int'(if1.busy),   0);
      chk("midrst_done",   int'(if1.done),   0);
      chk("midrst_result", int'(if1.result), 0);
      chk("midrst_eq",     int'(if1.eq),     0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("midrst_idle", int'(if1.busy), 0);
      op(0, 32'h00000005, 32'h00000003, 1'b0, "busy_after_rst");

      // DIGIT=4 instance
      op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "d4_busy_eq");
      op(1, 32'h7FFFFFFF, 32'h80000000, 1'b1, "d4_busy_s");
      op(1, 32'h7FFFFFFF, 32'h80000000, 1'b0, "d4_busy_u");
      op(1, 32'h12345678, 32'h12345679, 1'b0, "d4_busy_last");
      for (int i = 0; i < 4; i++)
         op(1, $urandom, $urandom, 1'(i & 1), "d4_busy_rand");

      repeat (3) @(negedge clk);
      chk("q1_left", q1.size(), 0);
      chk("q4_left", q4.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
